mac_dot_acc: RTL and testbench
==============================

Name: mac_dot_acc

Overview:
- Parametrised successor of the saturating pipelined 14x14 MAC.
- Signed multiply-accumulate with configurable operand/accumulator widths and multiplier pipeline depth.
- Adds a runtime dot-product window: accumulates LEN terms, emits one result, then restarts from zero. Also reports sticky saturation per window.
- Sits between the operand streamer and the result collector in the convolution datapath.

Parameters:
- IN_W, 14: signed operand width of a and b.
- ACC_W, 28: signed accumulator/result width. Must be >= 2*IN_W (elaboration error otherwise).
- MULT_STAGES, 3: register stages inside the multiplier. Legal range 1..4. Implemented as a behavioural multiply followed by a MULT_STAGES-deep register chain.
- LEN_W, 8: width of the window-length input.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a  in  IN_W  signed operand A.
- b  in  IN_W  signed operand B.
- valid_in  in  1  a/b are valid this cycle.
- len  in  LEN_W  window length in terms. 0 = continuous (legacy) mode.
- f  out  ACC_W  signed accumulator value.
- valid_out  out  1  f holds a completed result this cycle.
- ovf  out  1  saturation occurred in the window reported with valid_out.

Behaviour:
- Reset: on an edge with reset=1, all pipeline registers, valid bits, f, ovf, valid_out, term counter and latched length go to 0. In-flight terms are dropped. Reset takes priority over every other event.
- Pipeline, for a term sampled at edge k:
  - Edge k: input registers load a, b (only when valid_in=1).
  - Edges k+1..k+MULT_STAGES: product 2*IN_W bits, full precision, through the multiplier chain.
  - Edge k+MULT_STAGES+1: product register loads the product, sign-extended to ACC_W.
  - Edge k+MULT_STAGES+2: accumulator updates.
- Latency: MULT_STAGES+2 edges from valid_in sample to valid_out (5 at defaults).
- Valid tracking: one valid bit per stage. Each stage register loads only when its valid bit is set, otherwise it holds. Throughput is one term per cycle; bubbles are allowed anywhere.
- Accumulate: sum = acc + p (or 0 + p on the first term of a window), computed in ACC_W+1 bits. Clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1) on positive or negative overflow.
- Counter and window (for a valid term at the accumulator stage with cnt==0):
  - Latch len into len_q; cnt is the term count in the current window.
  - len_q==0 (continuous mode): never clear. valid_out=1 for every term. ovf = saturation on this term only.
  - len_q>0: cnt increments. On the term where cnt==len_q-1, valid_out=1 for one cycle, and cnt returns to 0. The next term starts from 0 + p.
- Length changes: a change on len mid-window is ignored until the next window start.
- ovf: sticky OR of saturation across the window. Presented with valid_out, then cleared when the next window starts.
- f: always shows the running accumulator. It is meaningful only when valid_out=1, and holds when no valid term arrives.
- valid_out=0 on all cycles without a completing term.
- Once saturated, the accumulator continues from the clamped value.

Test Plan (IN_W=14, ACC_W=28, MULT_STAGES=3):
1. len=0; (a,b)=(3,4) at edge 0, then (-2,5) at edge 1 -> valid_out=1 after edges 5 and 6; f=12 then f=2; ovf=0.
2. len=4; back-to-back (1,1),(2,2),(3,3),(4,4), then (5,5),(1,2),(0,0),(1,1) -> exactly two valid_out pulses, 5 edges after each window's last term: f=30 then f=28; no other valid_out.
3. Positive saturation: len=0; (8191,8191) x3 -> f=67092481, 134184962, then 134217727 with ovf=1 on the third only.
   Negative saturation: (-8192,8191) x3 -> f=-67100672, -134201344, then -134217728 with ovf=1.
4. Bubbles: len=3; valid_in pattern 1,0,0,1,0,1 with (2,3),(x),(x),(-4,1),(x),(7,7) -> single pulse 5 edges after the last valid term, f=51. Junk on a/b while valid_in=0 has no effect.
5. Reset mid-window: len=4; send two terms, assert reset for 1 cycle while they are in flight -> f=0, valid_out=0, ovf=0. No pulse from the dropped terms. A following 4-term window of (1,1) gives f=4.
6. Length change: len=2 at window start; switch len to 5 after the first term -> pulse after 2 terms. The next window uses len=5.

Source files
------------

// File: rtl/mac_dot_acc.sv
// Signed pipelined multiply-accumulate with a runtime dot-product window.
// The accumulator stage saturates instead of wrapping. When len is non-zero,
// the block emits one result per window of len terms and then restarts from zero.
// When len is zero, it emits a running result on every term.
module mac_dot_acc #(
  parameter int unsigned IN_W        = 14,
  parameter int unsigned ACC_W       = 28,
  parameter int unsigned MULT_STAGES = 3,
  parameter int unsigned LEN_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic             valid_in,
  input  logic [LEN_W-1:0] len,
  output logic [ACC_W-1:0] f,
  output logic             valid_out,
  output logic             ovf
);

  localparam int unsigned PROD_W = 2 * IN_W;
  localparam int unsigned SUM_W  = ACC_W + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Reject parameter combinations the datapath cannot represent.
  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("mac_dot_acc: ACC_W must be >= 2*IN_W");
  end
  if (MULT_STAGES < 1 || MULT_STAGES > 4) begin : g_bad_mult_stages
    $error("mac_dot_acc: MULT_STAGES must be in 1..4");
  end

  // Input operand registers.
  logic signed [IN_W-1:0]   a_q, a_d;
  logic signed [IN_W-1:0]   b_q, b_d;
  logic                     in_v_q, in_v_d;

  // Multiplier register chain.
  logic signed [PROD_W-1:0] mul_q [MULT_STAGES];
  logic signed [PROD_W-1:0] mul_d [MULT_STAGES];
  logic [MULT_STAGES-1:0]   mul_v_q, mul_v_d;

  // Product register, sign-extended to the accumulator width.
  logic signed [ACC_W-1:0]  p_q, p_d;
  logic                     p_v_q, p_v_d;

  // Accumulator, window tracking and result flags.
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  logic                     vout_q, vout_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]         len_q, len_d;

  logic signed [PROD_W-1:0] prod_c;
  logic [LEN_W-1:0]         len_eff_c;
  logic                     first_c;
  logic                     done_c;
  logic signed [ACC_W-1:0]  base_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic                     sat_c;
  logic signed [ACC_W-1:0]  clamp_c;

  // Full-precision product of the registered operands.
  assign prod_c = PROD_W'(a_q) * PROD_W'(b_q);

  // Window bookkeeping and saturating add for the term at the accumulator stage.
  // A new window latches len only on its first term, so a change on len
  // mid-window has no effect until the following window starts.
  always_comb begin
    len_eff_c = (cnt_q == '0) ? len : len_q;
    first_c   = (cnt_q == '0) && (len_eff_c != '0);
    done_c    = (len_eff_c == '0) || (cnt_q == len_eff_c - LEN_W'(1));
    base_c    = first_c ? '0 : acc_q;
    sum_c     = SUM_W'(base_c) + SUM_W'(p_q);
    sat_c     = sum_c[SUM_W-1] != sum_c[SUM_W-2];
    if (!sat_c) begin
      clamp_c = sum_c[ACC_W-1:0];
    end else if (sum_c[SUM_W-1]) begin
      clamp_c = ACC_MIN;
    end else begin
      clamp_c = ACC_MAX;
    end
  end

  // Next-state computation. Each data register loads only when its incoming
  // valid bit is set. The valid bits themselves advance every cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    in_v_d  = valid_in;
    mul_d   = mul_q;
    mul_v_d = '0;
    p_d     = p_q;
    p_v_d   = mul_v_q[MULT_STAGES-1];
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    vout_d  = 1'b0;
    cnt_d   = cnt_q;
    len_d   = len_q;

    if (valid_in) begin
      a_d = a;
      b_d = b;
    end

    mul_v_d[0] = in_v_q;
    if (in_v_q) begin
      mul_d[0] = prod_c;
    end
    for (int i = 1; i < int'(MULT_STAGES); i++) begin
      mul_v_d[i] = mul_v_q[i-1];
      if (mul_v_q[i-1]) begin
        mul_d[i] = mul_q[i-1];
      end
    end

    if (mul_v_q[MULT_STAGES-1]) begin
      p_d = ACC_W'(mul_q[MULT_STAGES-1]);
    end

    if (p_v_q) begin
      len_d  = len_eff_c;
      acc_d  = clamp_c;
      ovf_d  = sat_c | ((cnt_q != '0) & ovf_q);
      vout_d = done_c;
      cnt_d  = done_c ? '0 : cnt_q + LEN_W'(1);
    end
  end

  // State registers with synchronous reset that drops all in-flight terms.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      in_v_q  <= 1'b0;
      for (int i = 0; i < int'(MULT_STAGES); i++) begin
        mul_q[i] <= '0;
      end
      mul_v_q <= '0;
      p_q     <= '0;
      p_v_q   <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      vout_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      in_v_q  <= in_v_d;
      mul_q   <= mul_d;
      mul_v_q <= mul_v_d;
      p_q     <= p_d;
      p_v_q   <= p_v_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      vout_q  <= vout_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign f         = acc_q;
  assign valid_out = vout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_dot_acc.sv
// Directed bench for mac_dot_acc. Expected results are queued when the
// completing term is driven, and they are checked when valid_out appears.
module tb_mac_dot_acc;

  localparam int unsigned IN_W  = 14;
  localparam int unsigned ACC_W = 28;
  localparam int unsigned LEN_W = 8;
  localparam int          LAT   = 6; // negedge-to-negedge: drive, sample edge, +5 edges

  logic             clk = 1'b0;
  logic             reset;
  logic [IN_W-1:0]  a;
  logic [IN_W-1:0]  b;
  logic             valid_in;
  logic [LEN_W-1:0] len;
  logic [ACC_W-1:0] f;
  logic             valid_out;
  logic             ovf;

  typedef struct {
    logic [ACC_W-1:0] f;
    logic             ovf;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  mac_dot_acc #(
    .IN_W(IN_W), .ACC_W(ACC_W), .MULT_STAGES(3), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in),
    .len(len), .f(f), .valid_out(valid_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every valid_out pulse must match the oldest queued result.
  always @(negedge clk) begin
    exp_t e;
    if (valid_out !== 1'b0) begin
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_valid_out observed f=%0d valid_out=%b expected no pulse at cyc %0d",
               $signed(f), valid_out, cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_assert++;
        assert (f === e.f) else begin
          n_fail++;
          $error("FAIL result_f observed=%0d expected=%0d", $signed(f), $signed(e.f));
        end
        n_assert++;
        assert (ovf === e.ovf) else begin
          n_fail++;
          $error("FAIL result_ovf observed=%b expected=%b (f=%0d)", ovf, e.ovf, $signed(e.f));
        end
        n_assert++;
        assert (cyc === e.due) else begin
          n_fail++;
          $error("FAIL latency observed_cyc=%0d expected_cyc=%0d", cyc, e.due);
        end
      end
    end
  end

  task automatic term(input int aa, input int bb, input bit v);
    @(negedge clk);
    a        = IN_W'(aa);
    b        = IN_W'(bb);
    valid_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      a        = IN_W'($urandom);
      b        = IN_W'($urandom);
    end
  endtask

  task automatic push(input int ef, input bit eo);
    exp_t e;
    e.f   = ACC_W'(ef);
    e.ovf = eo;
    e.due = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    n_assert++;
    assert (f === '0) else begin
      n_fail++;
      $error("FAIL %s_f observed=%0d expected=0", tag, $signed(f));
    end
    n_assert++;
    assert (valid_out === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_valid_out observed=%b expected=0", tag, valid_out);
    end
    n_assert++;
    assert (ovf === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_ovf observed=%b expected=0", tag, ovf);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset");
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    len      = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_state("initial_reset");

    // 1. Continuous mode.
    len = 8'd0;
    term(3, 4, 1);  push(12, 0);
    term(-2, 5, 1); push(2, 0);
    idle(10);

    // 2. Two back-to-back windows of four terms.
    do_reset();
    len = 8'd4;
    term(1, 1, 1); term(2, 2, 1); term(3, 3, 1);
    term(4, 4, 1); push(30, 0);
    term(5, 5, 1); term(1, 2, 1); term(0, 0, 1);
    term(1, 1, 1); push(28, 0);
    idle(10);

    // 3a. Positive saturation in continuous mode.
    do_reset();
    len = 8'd0;
    term(8191, 8191, 1); push(67092481, 0);
    term(8191, 8191, 1); push(134184962, 0);
    term(8191, 8191, 1); push(134217727, 1);
    idle(10);

    // 3b. Negative saturation in continuous mode.
    do_reset();
    term(-8192, 8191, 1); push(-67100672, 0);
    term(-8192, 8191, 1); push(-134201344, 0);
    term(-8192, 8191, 1); push(-134217728, 1);
    idle(10);

    // 4. Bubbles with junk on idle operand cycles.
    do_reset();
    len = 8'd3;
    term(2, 3, 1);
    term(1234, -999, 0);
    term(-77, 4000, 0);
    term(-4, 1, 1);
    term(8191, 8191, 0);
    term(7, 7, 1); push(51, 0);
    idle(10);

    // 5. Reset while two terms are in flight, then a clean window.
    do_reset();
    len = 8'd4;
    term(5, 6, 1);
    term(7, 8, 1);
    @(negedge clk);
    valid_in = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("mid_window_reset");
    idle(8);
    term(1, 1, 1); term(1, 1, 1); term(1, 1, 1);
    term(1, 1, 1); push(4, 0);
    idle(10);

    // 6. Length change after the first term is accumulated.
    do_reset();
    len = 8'd2;
    term(1, 2, 1);
    idle(6);
    len = 8'd5;
    term(3, 1, 1); push(5, 0);
    term(1, 1, 1); term(1, 1, 1); term(1, 1, 1); term(1, 1, 1);
    term(1, 1, 1); push(5, 0);
    idle(12);

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL missing_results observed_pending=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
